// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: FSM state, FIFO entry layout
// and a saturating adder for the optional statistics counters.
package fetch_pkg;

   localparam int          INSTR_W = 32;
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of fetch entries; head is visible the cycle after its push, no bypass.
// Backpressure: caller must not push when full unless popping; flush beats push and pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  fetch_entry_t  push_dat_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output fetch_entry_t  head_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count_q;

   assign head_o  = mem[rd_ptr];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

   always_ff @(posedge clk_i) begin
      if (!rst_i || flush_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wr_ptr <= wr_ptr + AW'(1);
         if (pop_i)  rd_ptr <= rd_ptr + AW'(1);
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem[wr_ptr] <= push_dat_i;
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetcher with one outstanding imem request, buffered in a FIFO.
// Ack -> inst_valid_o one cycle later; stops issuing when full. FETCH_STATS_EN adds counters.
module instr_fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   input  logic        inst_ready_i
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] stat_fetched_o,
   output logic [31:0] stat_flushed_o
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state_q;
   logic [31:0]   fetch_pc_q;
   logic [31:0]   next_pc;
   logic [31:0]   target_pc;
   logic          push;
   logic          pop;
   logic          room_after_push;
   logic [CW-1:0] cnt_after_push;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   fetch_entry_t  push_dat;
   fetch_entry_t  head;
   fetch_entry_t  hold_q;

   assign target_pc = redirect_pc_i & ~32'h3;
   assign next_pc   = fetch_pc_q + PC_STEP;

   assign inst_valid_o = !fifo_empty;
   assign pop  = inst_valid_o && inst_ready_i && !redirect_i;
   assign push = (state_q == WAIT) && imem_ack_i && !redirect_i;

   assign push_dat.pc    = fetch_pc_q;
   assign push_dat.instr = imem_data_i;

   // Only evaluated while WAIT, where count < DEPTH, so the sum cannot overflow CW.
   assign cnt_after_push  = fifo_count + CW'(1) - CW'(pop);
   assign room_after_push = cnt_after_push < CW'(DEPTH);

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (push),
      .push_dat_i (push_dat),
      .pop_i      (pop),
      .flush_i    (redirect_i),
      .head_o     (head),
      .count_o    (fifo_count),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         fetch_pc_q  <= RESET_PC;
         imem_req_o  <= 1'b0;
         imem_addr_o <= RESET_PC;
      end else begin
         case (state_q)
            IDLE: begin
               if (redirect_i) begin
                  fetch_pc_q <= target_pc;
               end else if (!fifo_full) begin
                  state_q     <= WAIT;
                  imem_req_o  <= 1'b1;
                  imem_addr_o <= fetch_pc_q;
               end
            end
            WAIT: begin
               if (redirect_i) begin
                  fetch_pc_q <= target_pc;
                  if (imem_ack_i) begin
                     state_q    <= IDLE;
                     imem_req_o <= 1'b0;
                  end else begin
                     // Memory cannot cancel: keep the old request up and drop its data later.
                     state_q <= DISCARD;
                  end
               end else if (imem_ack_i) begin
                  fetch_pc_q <= next_pc;
                  if (room_after_push) begin
                     imem_addr_o <= next_pc;
                  end else begin
                     state_q    <= IDLE;
                     imem_req_o <= 1'b0;
                  end
               end
            end
            DISCARD: begin
               if (redirect_i) fetch_pc_q <= target_pc;
               if (imem_ack_i) begin
                  state_q    <= IDLE;
                  imem_req_o <= 1'b0;
               end
            end
            default: begin
               state_q    <= IDLE;
               imem_req_o <= 1'b0;
            end
         endcase
      end
   end

   // Last visible head, so outputs stay put while the queue is empty.
   always_ff @(posedge clk_i) begin
      if (!rst_i) hold_q <= '0;
      else if (!fifo_empty) hold_q <= head;
   end

   assign inst_o    = fifo_empty ? hold_q.instr : head.instr;
   assign inst_pc_o = fifo_empty ? hold_q.pc    : head.pc;

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         stat_fetched_o <= '0;
         stat_flushed_o <= '0;
      end else begin
         if (push) stat_fetched_o <= sat_add(stat_fetched_o, 32'd1);
         // A redirect while WAIT orphans the in-flight response; DISCARD already counted it.
         if (redirect_i)
            stat_flushed_o <= sat_add(stat_flushed_o,
                                      32'(fifo_count) + 32'(state_q == WAIT));
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: memory responder plus a PC-ordered scoreboard of expected deliveries.
module tb_instr_fetch_queue;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_data_i;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_ready_i = 1'b0;
`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched_o;
   logic [31:0] stat_flushed_o;
`endif

   int checks = 0;
   int fails  = 0;
   logic [31:0] sb_q[$];

   bit          mem_en   = 1'b1;
   int          mem_lat  = 0;
   int          lat_cnt  = 0;
   int          mem_acks = 0;
   logic        mdl_ack  = 1'b0;
   logic [31:0] mdl_data = '0;
   logic        man_ack  = 1'b0;
   logic [31:0] man_data = '0;

   assign imem_ack_i  = mem_en ? mdl_ack  : man_ack;
   assign imem_data_i = mem_en ? mdl_data : man_data;

   always #5 clk_i = ~clk_i;

   instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_data_i   (imem_data_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .inst_valid_o  (inst_valid_o),
      .inst_o        (inst_o),
      .inst_pc_o     (inst_pc_o),
      .inst_ready_i  (inst_ready_i)
`ifdef FETCH_STATS_EN
      ,
      .stat_fetched_o(stat_fetched_o),
      .stat_flushed_o(stat_flushed_o)
`endif
   );

   function automatic logic [31:0] word_of(input logic [31:0] pc);
      return pc ^ 32'h5EED_C0DE;
   endfunction

   // Memory responder: acks mem_lat cycles after it first sees a request.
   always @(negedge clk_i) begin
      if (mem_en && rst_i && imem_req_o) begin
         if (lat_cnt >= mem_lat) begin
            mdl_ack  = 1'b1;
            mdl_data = word_of(imem_addr_o);
            lat_cnt  = 0;
            mem_acks++;
         end else begin
            mdl_ack = 1'b0;
            lat_cnt++;
         end
      end else begin
         mdl_ack = 1'b0;
         lat_cnt = 0;
      end
   end

   // Scoreboard: every transfer must match the next expected PC and its word.
   always @(negedge clk_i) begin
      logic [31:0] exp_pc;
      if (rst_i && inst_valid_o && inst_ready_i && !redirect_i) begin
         checks++;
         if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: delivered pc=%h instr=%h, required no delivery", inst_pc_o, inst_o);
         end else begin
            exp_pc = sb_q.pop_front();
            if (inst_pc_o !== exp_pc || inst_o !== word_of(exp_pc)) begin
               fails++;
               $display("FAIL sb_entry: got pc=%h instr=%h, required pc=%h instr=%h",
                        inst_pc_o, inst_o, exp_pc, word_of(exp_pc));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i      = 1'b0;
      redirect_i = 1'b0;
      man_ack    = 1'b0;
      inst_ready_i = 1'b0;
      sb_q.delete();
      step();
      step();
   endtask

   task automatic drain(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (sb_q.size() == 0) break;
         step();
      end
      inst_ready_i = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("FAIL %s_drain: %0d entries still expected, required 0", name, sb_q.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctl: req=%b valid=%b, required 0 0", imem_req_o, inst_valid_o);
      end
      checks++;
      if (imem_addr_o !== 32'h0 || inst_o !== 32'h0 || inst_pc_o !== 32'h0) begin
         fails++;
         $display("FAIL reset_dat: addr=%h inst=%h pc=%h, required all 0", imem_addr_o, inst_o, inst_pc_o);
      end
`ifdef FETCH_STATS_EN
      checks++;
      if (stat_fetched_o !== 32'd0 || stat_flushed_o !== 32'd0) begin
         fails++;
         $display("FAIL reset_stats: fetched=%0d flushed=%0d, required 0 0", stat_fetched_o, stat_flushed_o);
      end
`endif
   endtask

   task automatic test_sequential();
      int cycles;
      do_reset();
      mem_en = 1'b1;
      mem_lat = 1;
      inst_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) sb_q.push_back(32'(i * 4));
      rst_i = 1'b1;
      cycles = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         cycles++;
         if (inst_valid_o) break;
      end
      checks++;
      if (cycles != 3) begin
         fails++;
         $display("FAIL seq_first_valid: valid after %0d cycles, required 3", cycles);
      end
      drain("seq", 80);
   endtask

   task automatic test_full();
      do_reset();
      mem_en = 1'b1;
      mem_lat = 0;
      mem_acks = 0;
      rst_i = 1'b1;
      repeat (10) step();
      checks++;
      if (mem_acks != 4) begin
         fails++;
         $display("FAIL full_pushes: %0d acks, required 4", mem_acks);
      end
      checks++;
      if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b1 || inst_pc_o !== 32'h0) begin
         fails++;
         $display("FAIL full_state: req=%b valid=%b pc=%h, required 0 1 00000000", imem_req_o, inst_valid_o, inst_pc_o);
      end
`ifdef FETCH_STATS_EN
      checks++;
      if (stat_fetched_o !== 32'd4) begin
         fails++;
         $display("FAIL full_stat_fetched: %0d, required 4", stat_fetched_o);
      end
`endif
      for (int i = 0; i < 6; i++) sb_q.push_back(32'(i * 4));
      inst_ready_i = 1'b1;
      drain("full", 60);
   endtask

   task automatic test_redirect_wait();
      do_reset();
      mem_en = 1'b0;
      inst_ready_i = 1'b1;
      rst_i = 1'b1;
      step();
      redirect_i = 1'b1;
      redirect_pc_i = 32'h40;
      step();
      redirect_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            fails++;
            $display("FAIL rw_hold%0d: req=%b addr=%h, required 1 00000000", k, imem_req_o, imem_addr_o);
         end
`ifdef FETCH_STATS_EN
         if (k == 0) begin
            checks++;
            if (stat_flushed_o !== 32'd1) begin
               fails++;
               $display("FAIL rw_stat_flushed: %0d, required 1", stat_flushed_o);
            end
         end
`endif
         if (k < 2) step();
      end
      man_ack = 1'b1;
      man_data = word_of(32'h0);
      step();
      man_ack = 1'b0;
      checks++;
      if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL rw_drop: req=%b valid=%b, required 0 0", imem_req_o, inst_valid_o);
      end
      step();
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
         fails++;
         $display("FAIL rw_target: req=%b addr=%h, required 1 00000040", imem_req_o, imem_addr_o);
      end
      sb_q.push_back(32'h40);
      man_ack = 1'b1;
      man_data = word_of(32'h40);
      step();
      man_ack = 1'b0;
      drain("rw", 10);
   endtask

   task automatic test_redirect_ack();
      do_reset();
      mem_en = 1'b0;
      inst_ready_i = 1'b1;
      rst_i = 1'b1;
      step();
      step();
      redirect_i = 1'b1;
      redirect_pc_i = 32'h80;
      man_ack = 1'b1;
      man_data = word_of(32'h0);
      step();
      redirect_i = 1'b0;
      man_ack = 1'b0;
      checks++;
      if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL ra_drop: req=%b valid=%b, required 0 0", imem_req_o, inst_valid_o);
      end
      step();
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h80) begin
         fails++;
         $display("FAIL ra_target: req=%b addr=%h, required 1 00000080", imem_req_o, imem_addr_o);
      end
      sb_q.push_back(32'h80);
      man_ack = 1'b1;
      man_data = word_of(32'h80);
      step();
      man_ack = 1'b0;
      drain("ra", 10);
   endtask

   task automatic test_wrap();
      do_reset();
      mem_en = 1'b1;
      mem_lat = 0;
      inst_ready_i = 1'b1;
      sb_q.push_back(32'hFFFF_FFFC);
      for (int i = 0; i < 3; i++) sb_q.push_back(32'(i * 4));
      redirect_i = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFE;
      rst_i = 1'b1;
      step();
      redirect_i = 1'b0;
      drain("wrap", 40);
   endtask

   task automatic test_reset_mid();
      do_reset();
      mem_en = 1'b0;
      inst_ready_i = 1'b1;
      rst_i = 1'b1;
      step();
      sb_q.push_back(32'h0);
      man_ack = 1'b1;
      man_data = word_of(32'h0);
      step();
      man_ack = 1'b0;
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
         fails++;
         $display("FAIL rm_b2b: req=%b addr=%h, required 1 00000004", imem_req_o, imem_addr_o);
      end
      drain("rm", 5);
      inst_ready_i = 1'b1;
      rst_i = 1'b0;
      step();
      checks++;
      if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || imem_addr_o !== 32'h0) begin
         fails++;
         $display("FAIL rm_cleared: req=%b valid=%b addr=%h, required 0 0 00000000", imem_req_o, inst_valid_o, imem_addr_o);
      end
`ifdef FETCH_STATS_EN
      checks++;
      if (stat_fetched_o !== 32'd0 || stat_flushed_o !== 32'd0) begin
         fails++;
         $display("FAIL rm_stats: fetched=%0d flushed=%0d, required 0 0", stat_fetched_o, stat_flushed_o);
      end
`endif
      rst_i = 1'b1;
      man_ack = 1'b1;
      man_data = word_of(32'h4);
      step();
      man_ack = 1'b0;
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || inst_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL rm_restart: req=%b addr=%h valid=%b, required 1 00000000 0", imem_req_o, imem_addr_o, inst_valid_o);
      end
      step();
      checks++;
      if (inst_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL rm_late_ack: valid=%b, required 0", inst_valid_o);
      end
      inst_ready_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_full();
      test_redirect_wait();
      test_redirect_ack();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
